stream_source: RTL

- Packet source driving the valid/last/data/ready byte-stream interface. It is the transmitting end that feeds the stream sink stage.
- On a start command it emits one packet of pkt_len beats with an incrementing data pattern from a seed, honouring downstream backpressure on ready_in.
- Used as a traffic generator in front of mux/sink paths, and as the transmit side of loopback tests.

---
 rtl/stream_pkg.sv | 13 +
 rtl/beat_counter.sv | 41 ++++
 rtl/stream_source.sv | 102 ++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared types and default widths for the byte-stream source, sink and mux blocks.
package stream_pkg;

    localparam int STREAM_DATA_W = 8;
    localparam int STREAM_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/beat_counter.sv
// Loadable beat counter that tracks position within a packet of captured length.
// last_next flags that the beat about to be presented (after load or increment) is the final one.
module beat_counter
    import stream_pkg::*;
#(
    parameter int LEN_W = STREAM_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             last_next
);

    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;

    // count holds the 1-based index of the beat currently being presented
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            len_q <= '0;
        end else if (load) begin
            count <= LEN_W'(1);
            len_q <= len;
        end else if (inc) begin
            count <= count + LEN_W'(1);
        end
    end

    always_comb begin
        last_next = 1'b0;
        if (load) begin
            last_next = (len == LEN_W'(1));
        end else begin
            last_next = ((count + LEN_W'(1)) == len_q);
        end
    end

endmodule

// File: rtl/stream_source.sv
// Packet generator: on start emits pkt_len beats of seed, seed+1, ... with valid/ready handshake,
// then idles GAP_CYCLES cycles before accepting another start. All outputs registered.
module stream_source
    import stream_pkg::*;
#(
    parameter int DATA_W     = STREAM_DATA_W,
    parameter int LEN_W      = STREAM_LEN_W,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [DATA_W-1:0] seed,
    output logic              valid_out,
    output logic              last_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;
    logic             xfer;
    logic             last_next;

    assign accept = (state == IDLE) && start && (pkt_len != '0);
    assign xfer   = (state == SEND) && valid_out && ready_in;

    beat_counter #(
        .LEN_W(LEN_W)
    ) u_beats (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .inc       (xfer && !last_out),
        .len       (pkt_len),
        .last_next (last_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_count <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SEND;
                        data_out  <= seed;
                        valid_out <= 1'b1;
                        last_out  <= last_next;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    // Without a transfer every output holds, so a stalled beat stays stable
                    if (xfer) begin
                        if (last_out) begin
                            valid_out <= 1'b0;
                            last_out  <= 1'b0;
                            done      <= 1'b1;
                            pkt_count <= pkt_count + 16'd1;
                            gap_cnt   <= '0;
                            if (GAP_CYCLES > 0) begin
                                state <= GAP;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            data_out <= data_out + DATA_W'(1);
                            last_out <= last_next;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
